// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for a multicycle MIPS datapath. One instruction walks through
// FETCH / DECODE / EXEC / MEM / WB style states, so that one ALU, one register
// file and one unified memory can be reused across cycles. The ALU computes
// PC+4, the branch target and the execute result in different cycles.
// alu_op drives the downstream ALUControl block.
//
// Optional feature (compile-time macro PERF_CNT_EN):
//   defined   -> retired_cnt counts every instr_done pulse, including
//                illegal-instruction NOPs. Reset clears it and it wraps at
//                2^CNT_W.
//   undefined -> there is no counter logic and retired_cnt is tied to 0.
//
// Parameters:
//   CNT_W        width of retired_cnt
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; forces every output to 0
//   opcode       IR[31:26] from the instruction register
//   funct        IR[5:0] from the instruction register
//   zero         ALU zero flag, used to resolve beq/bne
//   mem_ready    memory completes the current request this cycle
//   mem_req      memory request, held until mem_ready
//   mem_we       write strobe, only meaningful together with mem_req
//   iord         memory address select: 0 = PC, 1 = ALUOut
//   ir_write     load the instruction register
//   pc_write     load the PC
//   pc_src       PC source: 00 = ALU result, 01 = ALUOut, 10 = rs
//   alu_src_a    ALU A select: 0 = PC, 1 = A register
//   alu_src_b    ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
//   alu_op       operation class for ALUControl
//   reg_write    register file write enable
//   reg_dst      destination select: 0 = rt, 1 = rd
//   mem_to_reg   write-back source: 0 = ALUOut, 1 = MDR
//   instr_done   one-cycle pulse when an instruction retires
//   illegal      one-cycle pulse for an unsupported opcode or funct
//   retired_cnt  retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_R   = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM    = 4'd7,
        S_WB_LW  = 4'd8,
        S_BRANCH = 4'd9,
        S_JR     = 4'd10
    } state_t;

    state_t state;
    state_t next_state;
    logic   funct_ok;
    logic   is_sw;
    logic   is_bne;

    // State register. Reset always returns to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // R-type functions the datapath can execute. jr is handled separately in DECODE.
    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100111, 6'b000000, 6'b000010: funct_ok = 1'b1;
            default:                         funct_ok = 1'b0;
        endcase
    end

    assign is_sw  = (opcode == OP_SW);
    assign is_bne = (opcode == OP_BNE);

    // Next-state and Moore output decode. FETCH and MEM also use mem_ready so
    // that their loads/retires happen only when memory actually completes.
    // Unused state encodings fall into the default branch and go back to FETCH.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 4'b0000;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU computes the branch target here, speculatively, into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_R: begin
                        if (funct == FN_JR) begin
                            next_state = S_JR;
                        end else if (funct_ok) begin
                            next_state = S_EXEC_R;
                        end else begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                            next_state = S_FETCH;
                        end
                    end
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: next_state = S_EXEC_I;
                    OP_LW, OP_SW:                     next_state = S_ADDR;
                    OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = 4'b0111;
                next_state = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ORI:  alu_op = 4'b0001;
                    OP_ANDI: alu_op = 4'b0010;
                    OP_LUI:  alu_op = 4'b0011;
                    default: alu_op = 4'b0000;
                endcase
                next_state = S_WB_I;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = is_sw ? 4'b0101 : 4'b0100;
                next_state = S_MEM;
            end
            S_MEM: begin
                // Request and address stay asserted until memory completes.
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB_LW;
                    end
                end
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = is_bne ? 4'b1001 : 4'b1000;
                pc_src     = 2'b01;
                pc_write   = is_bne ? ~zero : zero;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JR: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // Reset silences everything, so a memory request in flight is dropped
        // in the same cycle.
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 4'b0000;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] retired_q;

    // Retired-instruction counter. It wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if (instr_done) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired_cnt = reset ? '0 : retired_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Scoreboard bench for multicycle_control_fsm. For every instruction it
// issues, the driver derives an expected per-instruction signature from the
// ISA rules. The signature covers latency, memory handshakes, write-backs,
// PC updates, ALU class and illegal flag. The driver pushes this signature
// into a queue. A monitor accumulates the same signature from the DUT outputs
// and compares the two on each instr_done pulse.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam int C_R = 0, C_JR = 1, C_I = 2, C_LW = 3, C_SW = 4,
                   C_BEQ = 5, C_BNE = 6, C_ILL = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] retired_cnt;

    typedef struct {
        int lat;
        int n_req;
        int n_iord;
        int n_irw;
        int n_pcw;
        int pcsrc;
        int n_regw;
        int regdst;
        int m2r;
        int n_we;
        int alu;
        int n_srca;
        int ill;
    } sig_t;

    sig_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    sig_t acc;

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // Compare one value, counting and reporting it.
    task automatic checkOutput(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Instruction class from the ISA tables.
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R: begin
                if (fn == 6'b001000) return C_JR;
                case (fn)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b100111, 6'b000000, 6'b000010: return C_R;
                    default: return C_ILL;
                endcase
            end
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: return C_I;
            OP_LW:  return C_LW;
            OP_SW:  return C_SW;
            OP_BEQ: return C_BEQ;
            OP_BNE: return C_BNE;
            default: return C_ILL;
        endcase
    endfunction

    // Reference signature of one instruction.
    function automatic sig_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int fw, input int mw);
        sig_t s;
        int   cls;
        bit   mem;
        bit   taken;
        cls   = classify(op, fn);
        mem   = (cls == C_LW) || (cls == C_SW);
        taken = (cls == C_JR) || (cls == C_BEQ && z) || (cls == C_BNE && !z);
        case (cls)
            C_R, C_I:            s.lat = fw + 4;
            C_SW:                s.lat = fw + 4 + mw;
            C_LW:                s.lat = fw + 5 + mw;
            C_BEQ, C_BNE, C_JR:  s.lat = fw + 3;
            default:             s.lat = fw + 2;
        endcase
        s.n_req  = fw + 1 + (mem ? mw + 1 : 0);
        s.n_iord = mem ? mw + 1 : 0;
        s.n_irw  = 1;
        s.n_pcw  = 1 + (taken ? 1 : 0);
        s.pcsrc  = (cls == C_JR) ? 2 : (taken ? 1 : 0);
        s.n_regw = (cls == C_R || cls == C_I || cls == C_LW) ? 1 : 0;
        s.regdst = (cls == C_R) ? 1 : 0;
        s.m2r    = (cls == C_LW) ? 1 : 0;
        s.n_we   = (cls == C_SW) ? mw + 1 : 0;
        case (cls)
            C_R:   s.alu = 7;
            C_I:   s.alu = (op == OP_ORI) ? 1 : (op == OP_ANDI) ? 2 : (op == OP_LUI) ? 3 : 0;
            C_LW:  s.alu = 4;
            C_SW:  s.alu = 5;
            C_BEQ: s.alu = 8;
            C_BNE: s.alu = 9;
            default: s.alu = 0;
        endcase
        s.n_srca = (cls == C_JR || cls == C_ILL) ? 0 : 1;
        s.ill    = (cls == C_ILL) ? 1 : 0;
        return s;
    endfunction

    // Push the expectation, then play the mem_ready schedule. Cycles where
    // mem_ready is irrelevant get random values.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int fw, input int mw);
        int mr[$];
        int cls;
        cls = classify(op, fn);
        exp_q.push_back(model(op, fn, z, fw, mw));
        for (int i = 0; i < fw; i++) mr.push_back(0);
        mr.push_back(1);
        mr.push_back(int'($urandom_range(0, 1)));
        case (cls)
            C_R, C_I: begin
                mr.push_back(int'($urandom_range(0, 1)));
                mr.push_back(int'($urandom_range(0, 1)));
            end
            C_LW, C_SW: begin
                mr.push_back(int'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) mr.push_back(0);
                mr.push_back(1);
                if (cls == C_LW) mr.push_back(int'($urandom_range(0, 1)));
            end
            C_BEQ, C_BNE, C_JR: mr.push_back(int'($urandom_range(0, 1)));
            default: ;
        endcase
        opcode = op;
        funct  = fn;
        zero   = z;
        foreach (mr[i]) begin
            mem_ready = mr[i][0];
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    function automatic sig_t clearSig();
        sig_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Monitor: accumulate the DUT signature and score it on each retire.
    always @(negedge clk) begin
        sig_t e;
        int   want_cnt;
        if (reset) begin
            acc       = clearSig();
            model_cnt = 0;
        end else begin
            acc.lat++;
            acc.n_req  += int'(mem_req);
            acc.n_iord += int'(iord);
            acc.n_irw  += int'(ir_write);
            acc.n_we   += int'(mem_we);
            acc.n_srca += int'(alu_src_a);
            acc.ill    += int'(illegal);
            if (pc_write) begin
                acc.n_pcw++;
                acc.pcsrc = int'(pc_src);
            end
            if (reg_write) begin
                acc.n_regw++;
                acc.regdst = int'(reg_dst);
                acc.m2r    = int'(mem_to_reg);
            end
            if (alu_op != 4'b0000) acc.alu = int'(alu_op);
            if (instr_done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_retire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("latency",    acc.lat,    e.lat);
                    checkOutput("mem_req",    acc.n_req,  e.n_req);
                    checkOutput("iord",       acc.n_iord, e.n_iord);
                    checkOutput("ir_write",   acc.n_irw,  e.n_irw);
                    checkOutput("pc_write",   acc.n_pcw,  e.n_pcw);
                    checkOutput("pc_src",     acc.pcsrc,  e.pcsrc);
                    checkOutput("reg_write",  acc.n_regw, e.n_regw);
                    checkOutput("reg_dst",    acc.regdst, e.regdst);
                    checkOutput("mem_to_reg", acc.m2r,    e.m2r);
                    checkOutput("mem_we",     acc.n_we,   e.n_we);
                    checkOutput("alu_op",     acc.alu,    e.alu);
                    checkOutput("alu_src_a",  acc.n_srca, e.n_srca);
                    checkOutput("illegal",    acc.ill,    e.ill);
                end
`ifdef PERF_CNT_EN
                want_cnt = model_cnt % (1 << CNT_W);
`else
                want_cnt = 0;
`endif
                checkOutput("retired_cnt", int'(retired_cnt), want_cnt);
                model_cnt++;
                acc = clearSig();
            end
        end
    end

    // Snapshot of every output, used for the all-zero reset checks.
    function automatic int allOutputs();
        return int'({mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, instr_done,
                     illegal}) | int'(retired_cnt);
    endfunction

    task automatic checkFirstFetch();
        @(negedge clk);
        checkOutput("post_reset_mem_req",   int'(mem_req),   1);
        checkOutput("post_reset_iord",      int'(iord),      0);
        checkOutput("post_reset_alu_op",    int'(alu_op),    0);
        checkOutput("post_reset_alu_src_b", int'(alu_src_b), 1);
    endtask

    logic [5:0] op_tbl [12];
    logic [5:0] fn_tbl [10];

    initial begin
        op_tbl = '{OP_R, OP_R, OP_R, OP_ADDI, OP_ORI, OP_ANDI, OP_LUI,
                   OP_LW, OP_SW, OP_BEQ, OP_BNE, 6'b111111};
        fn_tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                   6'b000000, 6'b000010, 6'b001000, 6'b101010, 6'b011000};

        reset     = 1'b1;
        opcode    = 6'b0;
        funct     = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("reset_outputs_zero", allOutputs(), 0);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        $display("[TB] reset released, starting directed instructions");

        fork
            checkFirstFetch();
        join_none
        applyStimulus(OP_R, 6'b100000, 1'b0, 1, 0);
        applyStimulus(OP_R, 6'b100000, 1'b0, 0, 0);
        applyStimulus(OP_LW, 6'b000000, 1'b0, 0, 2);
        applyStimulus(OP_BEQ, 6'b000000, 1'b1, 0, 0);
        applyStimulus(OP_BNE, 6'b000000, 1'b1, 0, 0);
        applyStimulus(6'b111111, 6'b000000, 1'b0, 0, 0);
        applyStimulus(OP_R, 6'b001000, 1'b0, 0, 0);
        applyStimulus(OP_SW, 6'b000000, 1'b0, 2, 1);

        $display("[TB] reset during a pending store");
        opcode = OP_SW;
        funct  = 6'b0;
        zero   = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("store_pending_mem_req", int'(mem_req), 1);
        checkOutput("store_pending_mem_we",  int'(mem_we),  1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_mem_outputs", allOutputs(), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] random instruction stream");
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = op_tbl[$urandom_range(0, 11)];
            if (op == 6'b111111) op = 6'($urandom);
            fn = fn_tbl[$urandom_range(0, 9)];
            applyStimulus(op, fn, 1'($urandom), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
